// File: rtl/perf_event_collector.sv
// Performance event collector: saturating live counters, a snapshot on request or interval,
// a valid/ready drain of the snapshot, and the free-running 64-bit cycle counter.
module perf_event_collector #(
   parameter int EVENT_NUM = 8,
   parameter int CNT_WIDTH = 32,
   parameter int INTERVAL  = 1024,
   parameter int IDX_WIDTH = (EVENT_NUM > 1) ? $clog2(EVENT_NUM) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en_i,
   input  logic [EVENT_NUM-1:0] event_i,
   input  logic                 dump_req_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [IDX_WIDTH-1:0] out_idx_o,
   output logic [CNT_WIDTH-1:0] out_cnt_o,
   output logic [63:0]          out_cycle_o,
   output logic                 out_last_o,
   output logic                 busy_o,
   output logic                 overrun_o,
   output logic [63:0]          cycle_cnt_o
);
   typedef enum logic {IDLE, DRAIN} state_e;

   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(EVENT_NUM - 1);

   state_e                              state_q, state_d;
   logic                                tick, trigger, snap;
   logic [EVENT_NUM-1:0][CNT_WIDTH-1:0] snap_val, shadow_all;
   logic [IDX_WIDTH-1:0]                idx_q, idx_d, nxt_idx;
   logic [CNT_WIDTH-1:0]                cnt_q, cnt_d;
   logic [63:0]                         cycle_q, out_cycle_q, out_cycle_d;
   logic                                last_q, last_d, overrun_q, overrun_d;

   assign trigger = dump_req_i || tick;
   assign snap    = (state_q == IDLE) && trigger;
   assign nxt_idx = idx_q + IDX_WIDTH'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cycle_q <= '0;
      else     cycle_q <= cycle_q + 64'd1;
   end

   if (INTERVAL > 0) begin : g_timer
      localparam int TW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
      logic [TW-1:0] timer_q;
      assign tick = (timer_q == TW'(INTERVAL - 1));
      always_ff @(posedge clk or posedge rst) begin
         if (rst)       timer_q <= '0;
         else if (tick) timer_q <= '0;
         else           timer_q <= timer_q + TW'(1);
      end
   end else begin : g_no_timer
      assign tick = 1'b0;
   end

   for (genvar gi = 0; gi < EVENT_NUM; gi++) begin : g_evt
      logic [CNT_WIDTH-1:0] live_q, shadow_q;
      logic                 inc;
      assign inc = en_i && event_i[gi];
      // Saturated next count; a snapshot in this cycle captures it so same-cycle events are kept.
      assign snap_val[gi]   = (inc && (live_q != '1)) ? live_q + CNT_WIDTH'(1) : live_q;
      assign shadow_all[gi] = shadow_q;
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            live_q   <= '0;
            shadow_q <= '0;
         end else if (snap) begin
            live_q   <= '0;
            shadow_q <= snap_val[gi];
         end else begin
            live_q   <= snap_val[gi];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         cnt_q       <= '0;
         last_q      <= 1'b0;
         out_cycle_q <= '0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         last_q      <= last_d;
         out_cycle_q <= out_cycle_d;
         overrun_q   <= overrun_d;
      end
   end

   // Record registers hold their last values in IDLE so the port never shows X.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      last_d      = last_q;
      out_cycle_d = out_cycle_q;
      overrun_d   = overrun_q || ((state_q == DRAIN) && trigger);
      case (state_q)
         IDLE: begin
            if (trigger) begin
               state_d     = DRAIN;
               idx_d       = '0;
               cnt_d       = snap_val[0];
               last_d      = (LAST_IDX == '0);
               out_cycle_d = cycle_q;
            end
         end
         DRAIN: begin
            if (out_ready_i) begin
               if (last_q) begin
                  state_d = IDLE;
               end else begin
                  idx_d  = nxt_idx;
                  cnt_d  = shadow_all[nxt_idx];
                  last_d = (nxt_idx == LAST_IDX);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign out_valid_o = (state_q == DRAIN);
   assign busy_o      = (state_q == DRAIN);
   assign out_idx_o   = idx_q;
   assign out_cnt_o   = cnt_q;
   assign out_last_o  = last_q;
   assign out_cycle_o = out_cycle_q;
   assign overrun_o   = overrun_q;
   assign cycle_cnt_o = cycle_q;
endmodule

// File: tb/tb_perf_event_collector.sv
// Directed bench: unit A (INTERVAL=0, CNT_WIDTH=8) for manual dumps, unit B (INTERVAL=16) for auto-dump.
module tb_perf_event_collector;
   logic        clk = 1'b0;
   logic        rst_a, en_a, dump_a, ready_a;
   logic [3:0]  event_a;
   logic        valid_a, last_a, busy_a, overrun_a;
   logic [1:0]  idx_a;
   logic [7:0]  cnt_a;
   logic [63:0] ocyc_a, cyc_cnt_a;

   logic        rst_b, en_b, dump_b, ready_b;
   logic [3:0]  event_b;
   logic        valid_b, last_b, busy_b, overrun_b;
   logic [1:0]  idx_b;
   logic [7:0]  cnt_b;
   logic [63:0] ocyc_b, cyc_cnt_b;

   int          n_total = 0;
   int          n_bad   = 0;
   logic [63:0] cyc_a;
   logic [63:0] ecyc;
   logic        sel;

   always #5 clk = ~clk;

   // Reference cycle count for unit A, used for expected out_cycle values.
   always @(posedge clk or posedge rst_a) begin
      if (rst_a) cyc_a <= '0;
      else       cyc_a <= cyc_a + 64'd1;
   end

   perf_event_collector #(.EVENT_NUM(4), .CNT_WIDTH(8), .INTERVAL(0)) u_a (
      .clk(clk), .rst(rst_a), .en_i(en_a), .event_i(event_a), .dump_req_i(dump_a),
      .out_valid_o(valid_a), .out_ready_i(ready_a), .out_idx_o(idx_a), .out_cnt_o(cnt_a),
      .out_cycle_o(ocyc_a), .out_last_o(last_a), .busy_o(busy_a), .overrun_o(overrun_a),
      .cycle_cnt_o(cyc_cnt_a)
   );

   perf_event_collector #(.EVENT_NUM(4), .CNT_WIDTH(8), .INTERVAL(16)) u_b (
      .clk(clk), .rst(rst_b), .en_i(en_b), .event_i(event_b), .dump_req_i(dump_b),
      .out_valid_o(valid_b), .out_ready_i(ready_b), .out_idx_o(idx_b), .out_cnt_o(cnt_b),
      .out_cycle_o(ocyc_b), .out_last_o(last_b), .busy_o(busy_b), .overrun_o(overrun_b),
      .cycle_cnt_o(cyc_cnt_b)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Called on the negedge after the snapshot edge; ev packs expected counts {idx3,idx2,idx1,idx0}.
   task automatic drain(input string tag, input bit stall, input logic [31:0] ev, input logic [63:0] ec);
      int          hs = 0;
      int          k  = 0;
      logic        r;
      logic        v, l, b;
      logic [1:0]  ix;
      logic [7:0]  c;
      logic [63:0] oc;
      while (hs < 4 && k < 40) begin
         r = stall ? (k % 3 == 0) : 1'b1;
         if (sel) ready_b = r; else ready_a = r;
         v  = sel ? valid_b : valid_a;
         l  = sel ? last_b  : last_a;
         b  = sel ? busy_b  : busy_a;
         ix = sel ? idx_b   : idx_a;
         c  = sel ? cnt_b   : cnt_a;
         oc = sel ? ocyc_b  : ocyc_a;
         check_val({tag, "_valid"}, 64'(v), 64'd1);
         check_val({tag, "_busy"}, 64'(b), 64'd1);
         check_val({tag, "_idx"}, 64'(ix), 64'(hs));
         check_val({tag, "_cnt"}, 64'(c), 64'(ev[8*hs +: 8]));
         check_val({tag, "_last"}, 64'(l), 64'(hs == 3));
         check_val({tag, "_cycle"}, oc, ec);
         if (r && v) begin
            $display("%s beat idx=%0d cnt=%0d last=%0b cycle=%0d", tag, ix, c, l, oc);
            hs++;
         end
         k++;
         @(negedge clk);
      end
      check_val({tag, "_handshakes"}, 64'(hs), 64'd4);
      check_val({tag, "_length"}, 64'(k), stall ? 64'd10 : 64'd4);
      check_val({tag, "_end_busy"}, 64'(sel ? busy_b : busy_a), 64'd0);
      check_val({tag, "_end_valid"}, 64'(sel ? valid_b : valid_a), 64'd0);
   endtask

   task automatic dump_a_now;
      dump_a = 1'b1;
      ecyc   = cyc_a;
      @(negedge clk);
      dump_a = 1'b0;
   endtask

   initial begin
      sel = 1'b0;
      rst_a = 1'b1; en_a = 1'b0; dump_a = 1'b0; ready_a = 1'b0; event_a = '0;
      rst_b = 1'b1; en_b = 1'b0; dump_b = 1'b0; ready_b = 1'b0; event_b = '0;
      repeat (2) @(negedge clk);
      check_val("rst_valid", 64'(valid_a), 64'd0);
      check_val("rst_busy", 64'(busy_a), 64'd0);
      check_val("rst_cycle", cyc_cnt_a, 64'd0);
      check_val("rst_cnt", 64'(cnt_a), 64'd0);
      check_val("rst_ocycle", ocyc_a, 64'd0);

      rst_a = 1'b0;
      repeat (100) @(negedge clk);
      check_val("idle_cycle", cyc_cnt_a, 64'd100);
      check_val("idle_valid", 64'(valid_a), 64'd0);
      check_val("idle_busy", 64'(busy_a), 64'd0);
      check_val("idle_overrun", 64'(overrun_a), 64'd0);

      // 10 event cycles plus the request cycle itself.
      en_a = 1'b1; event_a = 4'b0101; ready_a = 1'b1;
      repeat (10) @(negedge clk);
      dump_a_now();
      event_a = '0;
      drain("basic", 1'b0, {8'd0, 8'd11, 8'd0, 8'd11}, ecyc);

      // Live counters restarted; stalled drain.
      event_a = 4'b1000;
      repeat (3) @(negedge clk);
      event_a = '0;
      dump_a_now();
      drain("stall", 1'b1, {8'd3, 8'd0, 8'd0, 8'd0}, ecyc);

      en_a = 1'b0; event_a = 4'b1111;
      repeat (5) @(negedge clk);
      dump_a_now();
      event_a = '0; en_a = 1'b1;
      drain("en_off", 1'b0, 32'd0, ecyc);

      event_a = 4'b0001;
      repeat (300) @(negedge clk);
      dump_a_now();
      event_a = '0;
      drain("sat", 1'b0, {8'd0, 8'd0, 8'd0, 8'd255}, ecyc);
      check_val("a_overrun", 64'(overrun_a), 64'd0);

      // Reset in the middle of a stalled drain while events keep accumulating.
      event_a = 4'b0110;
      repeat (5) @(negedge clk);
      ready_a = 1'b0;
      dump_a_now();
      repeat (3) @(negedge clk);
      check_val("pre_rst_valid", 64'(valid_a), 64'd1);
      rst_a = 1'b1;
      #1;
      check_val("mid_rst_valid", 64'(valid_a), 64'd0);
      check_val("mid_rst_busy", 64'(busy_a), 64'd0);
      check_val("mid_rst_idx", 64'(idx_a), 64'd0);
      @(negedge clk);
      rst_a = 1'b0; event_a = 4'b0001;
      repeat (2) @(negedge clk);
      dump_a_now();
      event_a = '0;
      drain("post_rst", 1'b0, {8'd0, 8'd0, 8'd0, 8'd3}, ecyc);

      // Unit B: dump_req coincides with the first tick at edge 16.
      sel = 1'b1;
      rst_b = 1'b0; en_b = 1'b1; event_b = 4'b0010; ready_b = 1'b1;
      repeat (15) @(negedge clk);
      check_val("b_pre_busy", 64'(busy_b), 64'd0);
      dump_b = 1'b1;
      @(negedge clk);
      dump_b = 1'b0;
      check_val("b_cycle16", cyc_cnt_b, 64'd16);
      drain("coinc", 1'b0, {8'd0, 8'd0, 8'd16, 8'd0}, 64'd15);
      check_val("coinc_overrun", 64'(overrun_b), 64'd0);
      @(negedge clk);
      check_val("coinc_single", 64'(valid_b), 64'd0);

      // Auto-dump at edge 32 with consumer stalled; tick at edge 48 must be dropped.
      ready_b = 1'b0;
      repeat (11) @(negedge clk);
      check_val("auto_busy", 64'(busy_b), 64'd1);
      check_val("auto_cycle", ocyc_b, 64'd31);
      check_val("auto_overrun0", 64'(overrun_b), 64'd0);
      repeat (15) @(negedge clk);
      check_val("auto_overrun_pre", 64'(overrun_b), 64'd0);
      @(negedge clk);
      check_val("auto_overrun1", 64'(overrun_b), 64'd1);
      check_val("auto_nosnap_cycle", ocyc_b, 64'd31);
      check_val("auto_nosnap_idx", 64'(idx_b), 64'd0);
      drain("auto", 1'b0, {8'd0, 8'd0, 8'd16, 8'd0}, 64'd31);
      check_val("auto_overrun_sticky", 64'(overrun_b), 64'd1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
